// File: rtl/uart_rx_os.sv
//------------------------------------------------------------------------------
// uart_rx_os : 16x-oversampling UART receiver, majority-vote sampling,
//              framing check and one-byte valid/ready holding register.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_rx_os #(
    parameter int DIV       = 7,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 button,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic                 r_rx_meta;
    logic                 r_rx_s;
    logic [CW-1:0]        r_div_cnt;
    logic [3:0]           r_smp_cnt;
    logic [IW-1:0]        r_bit_idx;
    logic                 r_v7;
    logic                 r_v8;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_frame_err;
    logic                 r_overrun;

    logic                 w_tick;
    logic                 w_tick9;
    logic                 w_tick15;
    logic                 w_vote;
    logic                 w_start;
    logic                 w_load;
    logic                 w_ferr;

    always_ff @(posedge clk or negedge button) begin
        if (!button) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    assign w_tick   = (r_div_cnt == CW'(DIV - 1));
    assign w_tick9  = w_tick && (r_smp_cnt == 4'd9);
    assign w_tick15 = w_tick && (r_smp_cnt == 4'd15);
    // Third vote is the live sample at tick 9; ticks 7 and 8 were captured earlier.
    assign w_vote   = (r_v7 & r_v8) | (r_v7 & r_rx_s) | (r_v8 & r_rx_s);

    always_ff @(posedge clk or negedge button) begin
        if (!button) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_load      = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_rx_s) begin
                    w_state_nxt = S_START;
                    w_start     = 1'b1;
                end
            end
            S_START: begin
                if (w_tick9 && w_vote) begin
                    w_state_nxt = S_IDLE;
                end else if (w_tick15) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_tick15 && (r_bit_idx == IW'(DATA_BITS - 1))) begin
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                // Decide at mid-stop so a back-to-back start edge is not missed.
                if (w_tick9) begin
                    if (w_vote) begin
                        w_load      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_ferr      = 1'b1;
                        w_state_nxt = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (r_rx_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge button) begin
        if (!button) begin
            r_div_cnt <= '0;
            r_smp_cnt <= 4'd0;
            r_bit_idx <= '0;
            r_v7      <= 1'b1;
            r_v8      <= 1'b1;
            r_shift   <= '0;
        end else begin
            if (w_start || w_tick) begin
                r_div_cnt <= '0;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end

            if (w_start) begin
                r_smp_cnt <= 4'd0;
            end else if (w_tick) begin
                r_smp_cnt <= r_smp_cnt + 4'd1;
            end

            if (w_tick && (r_smp_cnt == 4'd7)) begin
                r_v7 <= r_rx_s;
            end
            if (w_tick && (r_smp_cnt == 4'd8)) begin
                r_v8 <= r_rx_s;
            end

            if ((r_state == S_DATA) && w_tick9) begin
                r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
            end

            if (w_start || ((r_state == S_START) && w_tick15)) begin
                r_bit_idx <= '0;
            end else if ((r_state == S_DATA) && w_tick15) begin
                r_bit_idx <= r_bit_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge button) begin
        if (!button) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_ferr;
            r_overrun   <= 1'b0;
            if (w_load) begin
                if (!r_valid || ready) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- 16x-oversampling UART receiver with an integrated baud-tick divider, majority-vote bit sampling, framing check and a one-byte output holding register.
- Replaces the one-bit-per-clock RX path and sits directly upstream of the transmit/echo logic.
- Delivers each received byte through a valid/ready handshake.

Parameters:
DIV, 7, clk cycles per oversample tick (baud = f_clk / (16*DIV)); legal range 1..65535
DATA_BITS, 8, data bits per frame; LSB first, no parity, one stop bit

Ports:
clk  input  1  system clock
button  input  1  reset, asynchronous, active-low
rx  input  1  asynchronous serial line, idle high
data  output  8  received byte, held stable while valid=1
valid  output  1  data holds an unconsumed byte
ready  input  1  consumer accepts data on a clk edge where valid=1 and ready=1
frame_err  output  1  one-cycle pulse: stop bit sampled 0
overrun  output  1  one-cycle pulse: a good byte was dropped because the holding register was full
busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (button=0, asynchronous): FSM=IDLE; synchroniser flops=1; tick counter=0; data=0; valid=0; frame_err=0; overrun=0; busy=0. Reset mid-frame discards the partial byte. The first frame after release is received normally.
- Synchroniser: rx passes through 2 flops to give rx_s. All decisions use rx_s only.
- Tick generator: counter runs 0..DIV-1 and tick=1 when counter==DIV-1. The counter is cleared on the IDLE->START transition, so ticks align to the detected edge. With DIV=1, tick is high every cycle.
- Sample counter: 4 bits, counts ticks 0..15 within each bit period. Majority vote uses rx_s at ticks 7, 8 and 9; bit value = at least 2 of 3.
- FSM states:
  - IDLE: when rx_s==0, go to START and clear both counters.
  - START: after the tick-9 vote, a majority of 1 is a glitch; return to IDLE with no output. Otherwise, at tick 15 go to DATA with bit index 0.
  - DATA: vote each bit and shift it into the shift register LSB-first. At tick 15, increment the index. After DATA_BITS bits go to STOP.
  - STOP: evaluate the tick-9 vote.
    - Vote=1: attempt a load into the holding register and go to IDLE. Remaining stop-bit time is not waited out, so a back-to-back start edge is caught.
    - Vote=0: pulse frame_err and do not load the byte. Go to BREAK.
  - BREAK: wait until rx_s==1, then go to IDLE. This keeps a held-low line from producing repeated frames.
- Load rules, evaluated on the cycle of the STOP decision:
  - valid=0: data<=byte, valid<=1.
  - valid=1 and ready=1 (simultaneous consume): data<=new byte, valid stays 1, no overrun.
  - valid=1 and ready=0: keep the old data, drop the new byte, pulse overrun.
- Consume: valid=1 and ready=1 with no simultaneous load sets valid<=0 on that edge. data is unchanged after consume.
- Latency: valid rises on the clk edge following the tick-9 stop-bit sample. This is about 9.6 bit times plus 2 synchroniser cycles after the falling start edge.
- frame_err and overrun are never high for more than one cycle per event.

Test Plan:
- DIV=1, frame 0x55 (16 clk/bit), ready=1 -> valid=1 for 1 cycle with data=0x55; frame_err=0; overrun=0; busy low again after STOP.
- DIV=1, rx low for 4 clks then high -> FSM returns to IDLE after START vote; valid, frame_err and overrun never assert.
- DIV=1, byte 0xA3 with stop bit driven 0 for 32 clks then high -> frame_err pulses once, valid stays 0; next frame 0x3C is received as 0x3C.
- DIV=3, ready=0, frames 0x12 then 0x34 back-to-back -> valid=1 with data=0x12, overrun pulses once at the 0x34 stop decision; ready=1 then clears valid and data stays 0x12.
- DIV=1, frame 0xF0 with a single-clk inversion at tick 8 of bit 2 -> data=0xF0 (majority vote rejects the glitch).
- DIV=1, assert button=0 mid-byte 4 of frame 0x77, release, send 0x81 -> all outputs 0 during reset; then valid with data=0x81 only.
